// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder with fixed programmable latency
module data_mem_responder #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [WIDTH-1:0]     req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  input  logic [WIDTH/8-1:0]   req_be,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_rdata,
  output logic                 rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic mis, accept, unused_addr;
  assign idx = req_addr[DEPTH_LOG2+1:2];
  assign mis = |req_addr[1:0];
  assign accept = req_valid & req_ready;
  assign unused_addr = ^req_addr[WIDTH-1:DEPTH_LOG2+2];
  // Stores commit at the acceptance edge so a following load sees them
  always_ff @(posedge clk)
    if (accept & req_we & ~mis)
      for (int i = 0; i < WIDTH/8; i++)
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            rsp_err   <= mis;
            rsp_rdata <= (req_we | mis) ? '0 : mem[idx];
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP:
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized scoreboard bench with a word-array reference model
module tb_data_mem_responder;
  localparam int L = 3;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_be = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int errors = 0, checks = 0, cyc = 0;
  bit hold_bp = 0, rr_rand = 0, in_rsp = 0;
  typedef struct {logic [31:0] d; logic e; int acc;} exp_t;
  exp_t q[$];
  logic [31:0] model [1024];

  data_mem_responder #(.WIDTH(32), .DEPTH_LOG2(10), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: byte-addressed word memory, index wraps modulo 1024 words
  function automatic exp_t model_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] be, input int acc);
    exp_t r;
    int w;
    w = int'((a >> 2) % 1024);
    r.acc = acc;
    r.e = (a % 4) != 0;
    r.d = 0;
    if (!r.e) begin
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) model[w][8*b +: 8] = d[8*b +: 8];
      end else r.d = model[w];
    end
    return r;
  endfunction

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    @(posedge clk);
    #1;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
      req_valid = 0;
      return;
    end
    q.push_back(model_op(we, a, d, be, cyc + 1));
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1 rsp_ready = hold_bp ? 1'b0 : (rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Monitor: compares every cycle a response is presented, pops on handshake
  always @(negedge clk) begin
    if (!rst) in_rsp = 0;
    else if (rsp_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got rdata %h err %b with nothing outstanding", rsp_rdata, rsp_err);
      end else begin
        if (!in_rsp) begin
          in_rsp = 1;
          chk("latency", cyc + 1, q[0].acc + L);
        end
        chk("rsp_rdata", rsp_rdata, q[0].d);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].e});
        chk("ready_in_resp", {31'b0, req_ready}, 0);
        if (rsp_ready) begin
          void'(q.pop_front());
          in_rsp = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] a;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 0);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 1);
    for (int i = 0; i < 16; i++) req(1, 32'((i < 8 ? 0 : 'h40) + i % 8) << 2, $urandom, 4'hF);
    req(1, 32'h100, 32'hDEADBEEF, 4'hF);
    req(0, 32'h100, 0, 0);
    req(1, 32'h100, 32'h11223344, 4'b0101);
    req(0, 32'h100, 0, 0);
    req(0, 32'h102, 0, 0);
    req(1, 32'h102, 32'h55555555, 4'hF);
    req(0, 32'h100, 0, 0);
    req(1, 32'h104, 32'h99999999, 4'h0);
    req(0, 32'h104, 0, 0);
    drain();
    hold_bp = 1;
    req(0, 32'h100, 0, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1; req_we = 1; req_addr = 32'h100; req_wdata = 32'h0BAD0BAD; req_be = 4'hF;
    repeat (6) begin
      @(negedge clk);
      chk("bp_req_ready", {31'b0, req_ready}, 0);
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 1);
    end
    @(posedge clk);
    #1 begin req_valid = 0; hold_bp = 0; end
    req(0, 32'h100, 0, 0);
    req(1, 32'h1000, 32'hCAFEF00D, 4'hF);
    req(0, 32'h0, 0, 0);
    drain();
    @(posedge clk);
    #1 begin req_valid = 1; req_we = 0; req_addr = 32'h100; end
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("wait_no_valid", {31'b0, rsp_valid}, 0);
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_rsp_valid", {31'b0, rsp_valid}, 0);
    end
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_idle_ready", {31'b0, req_ready}, 1);
    req(0, 32'h1000, 0, 0);
    rr_rand = 1;
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      a[11:2] = 10'(($urandom_range(0, 1) ? 'h40 : 0) + $urandom_range(0, 7));
      a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      req($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
